// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_if
//  Purpose  : req/ready data-memory bus between the load/store unit and memory
//  Revision : 1.0  initial release
// ============================================================================
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : multi-cycle load/store engine with stall, alignment fault, timeout
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              fault,
    output logic              err,
    load_store_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic        w_access;
    logic        w_legal;
    logic        w_size_ok;
    logic        w_f3_ok;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Legality and store-lane formatting of the current instruction
    always_comb begin
        w_access   = mem_read | mem_write;
        w_size_ok  = 1'b1;
        w_f3_ok    = 1'b0;
        w_st_wdata = 32'h0;
        w_st_wstrb = 4'b0000;
        case (funct3[1:0])
            2'b01:   w_size_ok = ~addr[0];
            2'b10:   w_size_ok = (addr[1:0] == 2'b00);
            default: w_size_ok = 1'b1;
        endcase
        if (mem_read && !mem_write) begin
            w_f3_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        end else if (mem_write && !mem_read) begin
            w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            case (funct3[1:0])
                2'b00: begin
                    w_st_wdata = {4{wdata[7:0]}};
                    w_st_wstrb = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    w_st_wdata = {2{wdata[15:0]}};
                    w_st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_st_wdata = wdata;
                    w_st_wstrb = 4'b1111;
                end
            endcase
        end
        w_legal = w_f3_ok & w_size_ok;
    end

    // Lane selection and extension of the returned word, using the latched access
    always_comb begin
        w_byte = 8'h0;
        w_load = 32'h0;
        case (off_q)
            2'b00:   w_byte = bus.bus_rdata[7:0];
            2'b01:   w_byte = bus.bus_rdata[15:8];
            2'b10:   w_byte = bus.bus_rdata[23:16];
            default: w_byte = bus.bus_rdata[31:24];
        endcase
        w_half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (f3_q)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = bus.bus_rdata;
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        data_d  = data_q;
        err_d   = err_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (w_access && w_legal) begin
                    state_d = S_REQ;
                    cnt_d   = 8'h0;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {addr[31:2], 2'b00};
                    wdata_d = w_st_wdata;
                    wstrb_d = w_st_wstrb;
                end
            end
            S_REQ: begin
                if (bus.bus_ready || (cnt_q == C_CNT_LAST)) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'h0;
                    wdata_d = 32'h0;
                    wstrb_d = 4'b0000;
                    // A successful response on the final allowed cycle still wins
                    if (bus.bus_ready) begin
                        data_d = we_q ? 32'h0 : w_load;
                    end else begin
                        data_d = 32'h0;
                        err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'h0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            data_q  <= data_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign stall = ((state_q == S_IDLE) && w_access && w_legal) || (state_q == S_REQ);
    assign fault = (state_q == S_IDLE) && w_access && !w_legal;
    assign rdata = (state_q == S_DONE) ? data_q : 32'h0;
    assign err   = err_q;

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory interface placed directly downstream of the single-cycle datapath's memory port. It takes the ALU-computed address, store data and access type, runs a req/ready handshake to a data memory that may insert wait states, and returns aligned, sign- or zero-extended load data on the datapath's read-data input. It also drives a stall that freezes PC and register-file writes while an access is outstanding, and it detects misaligned and illegal accesses.

## Interface

Parameters:
- TIMEOUT, default 255: maximum REQ cycles without bus_ready before the access is abandoned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; state clears on the rising clk edge while reset=0.
- mem_read  in  1  a load is requested by the current instruction.
- mem_write  in  1  a store is requested by the current instruction.
- funct3  in  3  access size and sign, from Instr[14:12].
- addr  in  32  byte address, from the datapath memory address.
- wdata  in  32  store data, from the datapath store data.
- rdata  out  32  extended load data to the datapath.
- stall  out  1  high means hold PC and suppress RegWrite this cycle.
- fault  out  1  pulses high for a misaligned or illegal access.
- err  out  1  sticky bus-timeout flag.
- bus_req  out  1  request valid.
- bus_we  out  1  1 means write.
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte enables; 0000 on reads.
- bus_ready  in  1  memory accepts or completes the request this cycle.
- bus_rdata  in  32  read word; valid when bus_ready=1 on a read.

## Operation

- FSM states: IDLE, REQ and DONE.
  - IDLE: if access=(mem_read|mem_write) and the access is legal, latch the bus_* fields and go to REQ. Otherwise stay in IDLE.
  - REQ: hold bus_req=1 and keep all bus_* fields stable. When bus_ready=1, capture the extended read data and go to DONE. When the counter reaches TIMEOUT-1 without bus_ready, set err=1, capture 0 and go to DONE.
  - DONE: lasts one cycle, during which the processor commits. Then return to IDLE, even if mem_read or mem_write is still high. This prevents relaunching the same access.
- stall = (IDLE & access & legal) | REQ. stall is 0 in DONE.
- Loads:
  - 000 LB: sign-extend the byte selected by addr[1:0].
  - 001 LH: sign-extend the halfword selected by addr[1].
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extended byte or halfword.
- Stores:
  - 000 SB: wdata replicated as {4{wdata[7:0]}}, wstrb = 0001<<addr[1:0].
  - 001 SH: wdata replicated as {2{wdata[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - 010 SW: wstrb = 1111.
- An access is illegal (fault=1 combinationally in IDLE, stall=0, no bus activity) when any of the following holds:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00;
  - loads with funct3 ∈ {011,110,111};
  - stores with funct3 ∉ {000,001,010};
  - mem_read=mem_write=1.
- rdata = DONE ? captured_data : 0. For stores, captured_data = 0.
- The REQ cycle counter is 8 bits wide (width sized to hold TIMEOUT). It clears on entry to REQ.
- err is cleared only by reset.

## Timing

- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_wstrb 0, rdata 0, stall 0, fault 0, err 0, counter 0.
- bus_* are registered and change only on the IDLE→REQ edge. They return to 0 on the edge leaving REQ.
- Zero-wait memory (bus_ready=1 in the first REQ cycle): the access occupies 3 cycles (IDLE-stalled, REQ, DONE), so the instruction takes 3 cycles. Each wait state adds 1 cycle.
- bus_ready sampled high in REQ cycle k gives rdata valid in cycle k+1 (DONE).
- bus_ready is ignored outside REQ.
- Timeout: bus_req is deasserted after exactly TIMEOUT REQ cycles. err rises in the DONE cycle.
- Reset asserted mid-REQ: on the next edge bus_req=0 and state=IDLE. No DONE cycle and no rdata are produced.

## Test plan

- LW at addr 0x100, bus_rdata=0xDEADBEEF, zero-wait -> stall high for 2 cycles, bus_addr=0x100, wstrb=0000, DONE rdata=0xDEADBEEF.
- LB at addr 0x103 and LBU at 0x103, bus_rdata=0x80FF_1234 -> rdata=0xFFFFFF80 for LB and 0x00000080 for LBU.
- SH at addr 0x202, wdata=0x1234ABCD, bus_ready delayed 3 cycles -> bus_wdata=0xABCDABCD, wstrb=1100, bus_addr=0x200, fields stable for 4 REQ cycles, stall high for 5 cycles total.
- LW at addr 0x101 -> fault=1, stall=0, bus_req stays 0. SB with funct3=011 -> fault=1.
- TIMEOUT=4, bus_ready tied 0 -> bus_req high exactly 4 cycles, then DONE with rdata=0, err=1 and held until reset.
- reset=0 on the second REQ cycle -> next edge bus_req=0, state IDLE, err=0, no DONE pulse.
